// File: rtl/alu_arbiter.sv
// alu_arbiter: round-robin sharing of one ALU between two valid/ready requesters.
// Optional MUL_2CYC_EN macro adds a MUL2 state giving `RMUL a two-cycle multicycle path.
`default_nettype none

`ifndef RA
`define RA   3'b000
`define RB   3'b001
`define RADD 3'b010
`define RSUB 3'b011
`define RAND 3'b100
`define ROR  3'b101
`define RXOR 3'b110
`define RMUL 3'b111
`endif

module alu_arbiter #(
    parameter int N = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [1:0]   req_valid,
    output logic [1:0]   req_ready,
    input  logic [N-1:0] req0_a,
    input  logic [N-1:0] req0_b,
    input  logic [2:0]   req0_func,
    input  logic [N-1:0] req1_a,
    input  logic [N-1:0] req1_b,
    input  logic [2:0]   req1_func,
    output logic [1:0]   rsp_valid,
    output logic [N-1:0] rsp_result,
    output logic         rsp_zf,
    output logic [N-1:0] alu_a,
    output logic [N-1:0] alu_b,
    output logic [2:0]   alu_func,
    input  logic [N-1:0] alu_result,
    input  logic         alu_zf
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EXEC = 2'd1,
`ifdef MUL_2CYC_EN
        S_RESP = 2'd2,
        S_MUL2 = 2'd3
`else
        S_RESP = 2'd2
`endif
    } state_e;

    state_e       state_q;
    logic         owner_q;
    logic         last_grant_q;
    logic [1:0]   rsp_valid_q;
    logic [N-1:0] rsp_result_q;
    logic         rsp_zf_q;
    logic [N-1:0] alu_a_q;
    logic [N-1:0] alu_b_q;
    logic [2:0]   alu_func_q;

    logic         winner;
    logic         accept;
    logic         capture;
    logic [N-1:0] sel_a;
    logic [N-1:0] sel_b;
    logic [2:0]   sel_func;

    always_comb begin
        // On a tie the requester that was not served last wins.
        winner   = (&req_valid) ? ~last_grant_q : req_valid[1];
        accept   = !reset && (|req_valid) && ((state_q == S_IDLE) || (state_q == S_RESP));
        req_ready = 2'b00;
        if (accept) begin
            req_ready = winner ? 2'b10 : 2'b01;
        end
        sel_a    = winner ? req1_a    : req0_a;
        sel_b    = winner ? req1_b    : req0_b;
        sel_func = winner ? req1_func : req0_func;
`ifdef MUL_2CYC_EN
        capture  = ((state_q == S_EXEC) && (alu_func_q != `RMUL)) || (state_q == S_MUL2);
`else
        capture  = (state_q == S_EXEC);
`endif
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= S_IDLE;
            owner_q      <= 1'b0;
            last_grant_q <= 1'b1;
            rsp_valid_q  <= 2'b00;
            rsp_result_q <= '0;
            rsp_zf_q     <= 1'b0;
            alu_a_q      <= '0;
            alu_b_q      <= '0;
            alu_func_q   <= `RA;
        end else begin
            rsp_valid_q <= 2'b00;
            if (capture) begin
                rsp_result_q <= alu_result;
                rsp_zf_q     <= alu_zf;
                rsp_valid_q  <= owner_q ? 2'b10 : 2'b01;
                state_q      <= S_RESP;
            end else if (accept) begin
                // Accept in IDLE or in the RESP cycle itself for back-to-back ops.
                alu_a_q      <= sel_a;
                alu_b_q      <= sel_b;
                alu_func_q   <= sel_func;
                owner_q      <= winner;
                last_grant_q <= winner;
                state_q      <= S_EXEC;
            end else if (state_q == S_RESP) begin
                state_q      <= S_IDLE;
`ifdef MUL_2CYC_EN
            end else if (state_q == S_EXEC) begin
                state_q      <= S_MUL2;
`endif
            end
        end
    end

    assign rsp_valid  = rsp_valid_q;
    assign rsp_result = rsp_result_q;
    assign rsp_zf     = rsp_zf_q;
    assign alu_a      = alu_a_q;
    assign alu_b      = alu_b_q;
    assign alu_func   = alu_func_q;

endmodule

`default_nettype wire
